tone_sequencer: RTL

TONE_SEQUENCER -- requirements
Module: tone_sequencer

---
 rtl/audio_pkg.sv | 37 +++
 rtl/tone_sequencer_square_gen.sv | 32 +++
 rtl/tone_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared types and the sound-effect note table for the tone sequencer.
package audio_pkg;

  typedef enum logic {IDLE, PLAY} state_t;

  // half = 0 is a rest; dur = 0 marks the end of a sequence.
  typedef struct packed {
    logic [17:0] half;
    logic [23:0] dur;
  } note_t;

  localparam int unsigned TBL_SEQS  = 4;
  localparam int unsigned TBL_NOTES = 8;

  localparam int unsigned SEQ_LOSE = 0;
  localparam int unsigned SEQ_WIN  = 1;
  localparam int unsigned SEQ_HOP  = 2;
  localparam int unsigned SEQ_TIME = 3;

  localparam note_t NOTE_TABLE [TBL_SEQS][TBL_NOTES] = '{
    '{'{18'd2, 24'd8}, '{18'd0, 24'd4}, '{18'd3, 24'd6}, '{18'd0, 24'd0},
      '{18'd0, 24'd0}, '{18'd0, 24'd0}, '{18'd0, 24'd0}, '{18'd0, 24'd0}},
    '{'{18'd1, 24'd4}, '{18'd2, 24'd8}, '{18'd3, 24'd6}, '{18'd4, 24'd8},
      '{18'd0, 24'd0}, '{18'd0, 24'd0}, '{18'd0, 24'd0}, '{18'd0, 24'd0}},
    '{'{18'd1, 24'd2}, '{18'd1, 24'd2}, '{18'd1, 24'd2}, '{18'd1, 24'd2},
      '{18'd1, 24'd2}, '{18'd1, 24'd2}, '{18'd1, 24'd2}, '{18'd1, 24'd2}},
    '{'{18'd0, 24'd0}, '{18'd0, 24'd0}, '{18'd0, 24'd0}, '{18'd0, 24'd0},
      '{18'd0, 24'd0}, '{18'd0, 24'd0}, '{18'd0, 24'd0}, '{18'd0, 24'd0}}
  };

  // Slots outside the table read as end markers.
  function automatic note_t note_at(input int unsigned s, input int unsigned n);
    if (s < TBL_SEQS && n < TBL_NOTES) return NOTE_TABLE[2'(s)][3'(n)];
    return '0;
  endfunction

endpackage

// File: rtl/tone_sequencer_square_gen.sv
// Square-wave phase generator: toggles every `half` enabled cycles, restarts high.
module square_gen #(
  parameter int HALF_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              enable,
  input  logic [HALF_W-1:0] half,
  output logic              phase
);

  logic [HALF_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= 1'b0;
      cnt   <= '0;
    end else if (restart) begin
      phase <= 1'b1;
      cnt   <= '0;
    end else if (enable) begin
      if (cnt >= half - HALF_W'(1)) begin
        phase <= ~phase;
        cnt   <= '0;
      end else begin
        cnt <= cnt + HALF_W'(1);
      end
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Plays a selected note sequence from the audio_pkg table as a square wave.
module tone_sequencer
  import audio_pkg::*;
#(
  parameter int NUM_SEQS  = 4,
  parameter int NUM_NOTES = 8,
  parameter int HALF_W    = 18,
  parameter int DUR_W     = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        trigger,
  input  logic [$clog2(NUM_SEQS)-1:0] seq_sel,
  input  logic                        stop,
  output logic                        sound_out,
  output logic                        busy,
  output logic                        done
);

  localparam int SEL_W = $clog2(NUM_SEQS);
  localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NOTES - 1);

  state_t            state, state_n;
  logic              prev_trig;
  logic [SEL_W-1:0]  seq, seq_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [HALF_W-1:0] cur_half, half_n;
  logic [DUR_W-1:0]  cur_dur, dur_n, dur_cnt, cnt_n;
  logic              done_r, done_n;
  logic              restart, phase, edge_det;
  note_t             first, nxt;

  assign edge_det = trigger & ~prev_trig;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prev_trig <= 1'b1;
      seq       <= '0;
      idx       <= '0;
      cur_half  <= '0;
      cur_dur   <= '0;
      dur_cnt   <= '0;
      done_r    <= 1'b0;
    end else begin
      state     <= state_n;
      prev_trig <= trigger;
      seq       <= seq_n;
      idx       <= idx_n;
      cur_half  <= half_n;
      cur_dur   <= dur_n;
      dur_cnt   <= cnt_n;
      done_r    <= done_n;
    end
  end

  // Priority: stop, then a fresh trigger edge, then normal note advance.
  always_comb begin
    state_n = state;
    seq_n   = seq;
    idx_n   = idx;
    half_n  = cur_half;
    dur_n   = cur_dur;
    cnt_n   = dur_cnt;
    done_n  = 1'b0;
    restart = 1'b0;
    first   = note_at(32'(seq_sel), 0);
    nxt     = note_at(32'(seq), 32'(idx) + 1);
    if (stop) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (edge_det) begin
      seq_n   = seq_sel;
      idx_n   = '0;
      cnt_n   = '0;
      restart = 1'b1;
      half_n  = HALF_W'(first.half);
      dur_n   = DUR_W'(first.dur);
      if (DUR_W'(first.dur) == '0) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end else begin
        state_n = PLAY;
      end
    end else if (state == PLAY) begin
      if (dur_cnt >= cur_dur - DUR_W'(1)) begin
        cnt_n = '0;
        if (idx == LAST || DUR_W'(nxt.dur) == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          idx_n   = idx + IDX_W'(1);
          half_n  = HALF_W'(nxt.half);
          dur_n   = DUR_W'(nxt.dur);
          restart = 1'b1;
        end
      end else begin
        cnt_n = dur_cnt + DUR_W'(1);
      end
    end
  end

  square_gen #(.HALF_W(HALF_W)) u_square (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .enable  ((state == PLAY) && (cur_half != '0)),
    .half    (cur_half),
    .phase   (phase)
  );

  assign busy      = (state == PLAY);
  assign done      = done_r;
  assign sound_out = busy & phase & (cur_half != '0);

endmodule
